// File: rtl/dport_hart_responder.sv
// Per-hart debug-port responder: serves one register-access request at a time,
// routing CSR accesses to the CSR unit and GPR/FPR accesses to the regfile debug port.
module dport_hart_responder #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned FPU_ENA = 1,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_nrst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_write,
    input  logic [15:0]     i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_resp_error,
    output logic            o_csr_req_valid,
    input  logic            i_csr_req_ready,
    output logic            o_csr_req_write,
    output logic [11:0]     o_csr_req_addr,
    output logic [XLEN-1:0] o_csr_req_data,
    input  logic            i_csr_resp_valid,
    output logic            o_csr_resp_ready,
    input  logic [XLEN-1:0] i_csr_resp_data,
    input  logic            i_csr_resp_exception,
    output logic [5:0]      o_ireg_addr,
    output logic            o_ireg_write,
    output logic [XLEN-1:0] o_ireg_wdata,
    input  logic [XLEN-1:0] i_ireg_rdata
);

    localparam int unsigned AW   = 16;
    localparam int unsigned CNTW = 8;
    localparam logic [CNTW-1:0] CNT_MAX = CNTW'(TIMEOUT);
    localparam logic [AW-1:0]   X0_ADDR = 16'h1000;

    typedef enum logic [2:0] {
        IDLE,
        CSR_REQ,
        CSR_RESP,
        REG,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              write_q, write_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              error_q, error_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;

    logic is_csr;
    logic is_gpr;
    logic is_fpr;

    // Address window decode of the incoming request
    always_comb begin
        is_csr = (i_req_addr[15:12] == 4'h0);
        is_gpr = (i_req_addr[15:5] == 11'h080);
        is_fpr = (FPU_ENA != 0) && (i_req_addr[15:5] == 11'h081);
    end

    // State and captured-request registers
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and state-owned outputs; every output is zero outside its owning state
    always_comb begin
        state_d          = state_q;
        addr_d           = addr_q;
        write_d          = write_q;
        wdata_d          = wdata_q;
        rdata_d          = rdata_q;
        error_d          = error_q;
        cnt_d            = cnt_q;
        o_req_ready      = 1'b0;
        o_resp_valid     = 1'b0;
        o_resp_rdata     = '0;
        o_resp_error     = 1'b0;
        o_csr_req_valid  = 1'b0;
        o_csr_req_write  = 1'b0;
        o_csr_req_addr   = '0;
        o_csr_req_data   = '0;
        o_csr_resp_ready = 1'b1;
        o_ireg_addr      = '0;
        o_ireg_write     = 1'b0;
        o_ireg_wdata     = '0;

        case (state_q)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    write_d = i_req_write;
                    addr_d  = i_req_addr;
                    wdata_d = i_req_wdata;
                    rdata_d = '0;
                    error_d = 1'b0;
                    cnt_d   = '0;
                    if (is_csr) begin
                        state_d = CSR_REQ;
                    end else if (is_gpr || is_fpr) begin
                        state_d = REG;
                    end else begin
                        error_d = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            CSR_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == CNT_MAX) begin
                    // Request withdrawn so a stuck CSR unit cannot hang the debugger
                    error_d = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    o_csr_req_valid = 1'b1;
                    o_csr_req_write = write_q;
                    o_csr_req_addr  = addr_q[11:0];
                    o_csr_req_data  = wdata_q;
                    if (i_csr_req_ready) begin
                        state_d = CSR_RESP;
                    end
                end
            end
            CSR_RESP: begin
                cnt_d = cnt_q + 8'd1;
                if (i_csr_resp_valid) begin
                    rdata_d = (write_q || i_csr_resp_exception) ? '0 : i_csr_resp_data;
                    error_d = i_csr_resp_exception;
                    state_d = RESP;
                end else if (cnt_q == CNT_MAX) begin
                    error_d = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end
            end
            REG: begin
                o_ireg_addr  = addr_q[5:0];
                o_ireg_write = write_q && (addr_q != X0_ADDR);
                o_ireg_wdata = wdata_q;
                if (!write_q) begin
                    rdata_d = i_ireg_rdata;
                end
                state_d = RESP;
            end
            RESP: begin
                o_resp_valid = 1'b1;
                o_resp_rdata = rdata_q;
                o_resp_error = error_q;
                if (i_resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dport_hart_responder.sv
// Bench for dport_hart_responder: table of register/error accesses plus CSR,
// timeout, reset and backpressure sequences.
module tb_dport_hart_responder;

    logic        clk;
    logic        rst_n;

    logic        req_valid, req_valid2;
    logic        req_ready, req_ready2;
    logic        write;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic        resp_valid, resp_valid2;
    logic        resp_ready;
    logic [63:0] resp_rdata, resp_rdata2;
    logic        resp_error, resp_error2;
    logic        csr_req_valid, csr_req_valid2;
    logic        csr_req_ready;
    logic        csr_req_write, csr_req_write2;
    logic [11:0] csr_req_addr, csr_req_addr2;
    logic [63:0] csr_req_data, csr_req_data2;
    logic        csr_resp_valid;
    logic        csr_resp_ready, csr_resp_ready2;
    logic [63:0] csr_resp_data;
    logic        csr_resp_exc;
    logic [5:0]  ireg_addr, ireg_addr2;
    logic        ireg_write, ireg_write2;
    logic [63:0] ireg_wdata, ireg_wdata2;
    logic [63:0] ireg_rdata, ireg_rdata2;

    int checks   = 0;
    int failures = 0;

    logic [63:0] rf [64];
    int          wr_cnt = 0;
    int          csr_cnt = 0;
    logic [5:0]  last_waddr = '0;
    logic [63:0] last_wdata = '0;
    logic        act2 = 1'b0;

    dport_hart_responder #(.XLEN(64), .FPU_ENA(0), .TIMEOUT(4)) u_dut (
        .i_clk(clk), .i_nrst(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(write), .i_req_addr(addr), .i_req_wdata(wdata),
        .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata), .o_resp_error(resp_error),
        .o_csr_req_valid(csr_req_valid), .i_csr_req_ready(csr_req_ready),
        .o_csr_req_write(csr_req_write), .o_csr_req_addr(csr_req_addr),
        .o_csr_req_data(csr_req_data),
        .i_csr_resp_valid(csr_resp_valid), .o_csr_resp_ready(csr_resp_ready),
        .i_csr_resp_data(csr_resp_data), .i_csr_resp_exception(csr_resp_exc),
        .o_ireg_addr(ireg_addr), .o_ireg_write(ireg_write),
        .o_ireg_wdata(ireg_wdata), .i_ireg_rdata(ireg_rdata)
    );

    dport_hart_responder #(.XLEN(64), .FPU_ENA(1), .TIMEOUT(255)) u_fpu (
        .i_clk(clk), .i_nrst(rst_n),
        .i_req_valid(req_valid2), .o_req_ready(req_ready2),
        .i_req_write(write), .i_req_addr(addr), .i_req_wdata(wdata),
        .o_resp_valid(resp_valid2), .i_resp_ready(resp_ready),
        .o_resp_rdata(resp_rdata2), .o_resp_error(resp_error2),
        .o_csr_req_valid(csr_req_valid2), .i_csr_req_ready(csr_req_ready),
        .o_csr_req_write(csr_req_write2), .o_csr_req_addr(csr_req_addr2),
        .o_csr_req_data(csr_req_data2),
        .i_csr_resp_valid(csr_resp_valid), .o_csr_resp_ready(csr_resp_ready2),
        .i_csr_resp_data(csr_resp_data), .i_csr_resp_exception(csr_resp_exc),
        .o_ireg_addr(ireg_addr2), .o_ireg_write(ireg_write2),
        .o_ireg_wdata(ireg_wdata2), .i_ireg_rdata(ireg_rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model with combinational read, plus activity monitors
    assign ireg_rdata  = rf[ireg_addr];
    assign ireg_rdata2 = rf[ireg_addr2];

    always @(posedge clk) begin
        if (ireg_write) begin
            rf[ireg_addr] <= ireg_wdata;
            wr_cnt        <= wr_cnt + 1;
            last_waddr    <= ireg_addr;
            last_wdata    <= ireg_wdata;
        end
        if (ireg_write2) begin
            rf[ireg_addr2] <= ireg_wdata2;
        end
        if (csr_req_valid) begin
            csr_cnt <= csr_cnt + 1;
        end
        if (csr_req_valid2 || csr_req_write2 || (csr_req_addr2 != 12'h0) || (csr_req_data2 != 64'h0)) begin
            act2 <= 1'b1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One complete request/response transaction on the selected instance
    task automatic do_req(input bit sel, input logic wr, input logic [15:0] a, input logic [63:0] d,
                          output int lat, output logic [63:0] rd, output logic er, output logic [5:0] ia);
        chk("req_ready_idle", 64'(sel ? req_ready2 : req_ready), 64'(1));
        write = wr;
        addr  = a;
        wdata = d;
        if (sel) req_valid2 = 1'b1;
        else     req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
        write = ~wr;
        addr  = a ^ 16'h0001;
        wdata = ~d;
        ia  = sel ? ireg_addr2 : ireg_addr;
        lat = 1;
        while (!(sel ? resp_valid2 : resp_valid) && lat < 40) begin
            tick();
            lat++;
        end
        rd = sel ? resp_rdata2 : resp_rdata;
        er = sel ? resp_error2 : resp_error;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("resp_valid_after_hs", 64'(sel ? resp_valid2 : resp_valid), 64'(0));
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] a;
        logic [63:0] d;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        logic [5:0]  iaddr;
        int          nwr;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        int          lat;
        logic [63:0] rd;
        logic        er;
        logic [5:0]  ia;
        int          w0;
        int          c0;

        vecs[0]  = '{1'b0, 16'h1005, 64'h0, 64'h1122334455667788, 1'b0, 2, 6'd5, 0};
        vecs[1]  = '{1'b1, 16'h1000, 64'hDEAD, 64'h0, 1'b0, 2, 6'd0, 0};
        vecs[2]  = '{1'b0, 16'h1000, 64'h0, 64'h0, 1'b0, 2, 6'd0, 0};
        vecs[3]  = '{1'b1, 16'h1001, 64'h0123456789ABCDEF, 64'h0, 1'b0, 2, 6'd1, 1};
        vecs[4]  = '{1'b0, 16'h1001, 64'h0, 64'h0123456789ABCDEF, 1'b0, 2, 6'd1, 0};
        vecs[5]  = '{1'b1, 16'h101F, 64'h77, 64'h0, 1'b0, 2, 6'd31, 1};
        vecs[6]  = '{1'b0, 16'h2000, 64'h0, 64'h0, 1'b1, 1, 6'd0, 0};
        vecs[7]  = '{1'b0, 16'h1020, 64'h0, 64'h0, 1'b1, 1, 6'd0, 0};
        vecs[8]  = '{1'b1, 16'h103F, 64'h5, 64'h0, 1'b1, 1, 6'd0, 0};
        vecs[9]  = '{1'b0, 16'h1040, 64'h0, 64'h0, 1'b1, 1, 6'd0, 0};
        vecs[10] = '{1'b1, 16'hFFFF, 64'h9, 64'h0, 1'b1, 1, 6'd0, 0};
        vecs[11] = '{1'b0, 16'h101F, 64'h0, 64'h77, 1'b0, 2, 6'd31, 0};

        for (int i = 0; i < 64; i++) rf[i] = 64'h0;
        rf[5]  = 64'h1122334455667788;
        rf[35] = 64'hF00DF00DCAFE0001;

        rst_n = 1'b0;
        req_valid = 1'b0; req_valid2 = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        resp_ready = 1'b0; csr_req_ready = 1'b0; csr_resp_valid = 1'b0;
        csr_resp_data = '0; csr_resp_exc = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", 64'(req_ready), 64'(1));
        chk("rst_csr_resp_ready", 64'(csr_resp_ready), 64'(1));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_csr_req_valid", 64'(csr_req_valid), 64'(0));
        chk("rst_ireg", {ireg_wdata[31:0], 25'h0, ireg_write, ireg_addr}, 64'h0);
        chk("rst_rdata", resp_rdata, 64'h0);
        rst_n = 1'b1;
        tick();

        // Table of register-file and error-address accesses
        for (int i = 0; i < NV; i++) begin
            w0 = wr_cnt;
            c0 = csr_cnt;
            do_req(1'b0, vecs[i].wr, vecs[i].a, vecs[i].d, lat, rd, er, ia);
            chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
            chk($sformatf("v%0d_error", i), 64'(er), 64'(vecs[i].err));
            chk($sformatf("v%0d_iaddr", i), 64'(ia), 64'(vecs[i].iaddr));
            chk($sformatf("v%0d_nwr", i), 64'(wr_cnt - w0), 64'(vecs[i].nwr));
            chk($sformatf("v%0d_csr_idle", i), 64'(csr_cnt - c0), 64'(0));
            if (vecs[i].nwr != 0) begin
                chk($sformatf("v%0d_waddr", i), 64'(last_waddr), 64'(vecs[i].iaddr));
                chk($sformatf("v%0d_wdata", i), last_wdata, vecs[i].d);
            end
        end

        // CSR read with the grant stalled for 3 cycles
        write = 1'b0; addr = 16'h0341; wdata = 64'h0; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; addr = 16'h0FFF;
        for (int k = 0; k < 3; k++) begin
            chk("csrA_valid_stall", 64'(csr_req_valid), 64'(1));
            chk("csrA_addr_stall", 64'(csr_req_addr), 64'h341);
            tick();
        end
        chk("csrA_valid_grant", 64'(csr_req_valid), 64'(1));
        chk("csrA_write", 64'(csr_req_write), 64'(0));
        csr_req_ready = 1'b1;
        tick();
        csr_req_ready = 1'b0;
        chk("csrA_valid_dropped", 64'(csr_req_valid), 64'(0));
        chk("csrA_no_resp_yet", 64'(resp_valid), 64'(0));
        csr_resp_valid = 1'b1; csr_resp_data = 64'hABC;
        tick();
        csr_resp_valid = 1'b0;
        chk("csrA_resp_valid", 64'(resp_valid), 64'(1));
        chk("csrA_rdata", resp_rdata, 64'hABC);
        chk("csrA_error", 64'(resp_error), 64'(0));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // CSR write answered with an exception
        write = 1'b1; addr = 16'h0300; wdata = 64'h1234; req_valid = 1'b1; csr_req_ready = 1'b1;
        tick();
        req_valid = 1'b0; wdata = 64'h0;
        chk("csrB_valid", 64'(csr_req_valid), 64'(1));
        chk("csrB_write", 64'(csr_req_write), 64'(1));
        chk("csrB_addr", 64'(csr_req_addr), 64'h300);
        chk("csrB_data", csr_req_data, 64'h1234);
        tick();
        csr_req_ready = 1'b0;
        csr_resp_valid = 1'b1; csr_resp_exc = 1'b1; csr_resp_data = 64'hFFFF;
        tick();
        csr_resp_valid = 1'b0; csr_resp_exc = 1'b0;
        chk("csrB_resp_valid", 64'(resp_valid), 64'(1));
        chk("csrB_error", 64'(resp_error), 64'(1));
        chk("csrB_rdata", resp_rdata, 64'h0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;

        // Timeout while waiting for the grant
        do_req(1'b0, 1'b0, 16'h0001, 64'h0, lat, rd, er, ia);
        chk("toC_lat", 64'(lat), 64'(6));
        chk("toC_error", 64'(er), 64'(1));
        chk("toC_rdata", rd, 64'h0);
        chk("toC_csr_valid_idle", 64'(csr_req_valid), 64'(0));

        // Timeout while waiting for the response, then a late response is dropped
        csr_req_ready = 1'b1;
        do_req(1'b0, 1'b0, 16'h0002, 64'h0, lat, rd, er, ia);
        csr_req_ready = 1'b0;
        chk("toD_lat", 64'(lat), 64'(6));
        chk("toD_error", 64'(er), 64'(1));
        chk("toD_rdata", rd, 64'h0);
        csr_resp_valid = 1'b1; csr_resp_data = 64'h999;
        chk("late_csr_resp_ready", 64'(csr_resp_ready), 64'(1));
        tick();
        csr_resp_valid = 1'b0;
        chk("late_no_resp", 64'(resp_valid), 64'(0));
        do_req(1'b0, 1'b0, 16'h1005, 64'h0, lat, rd, er, ia);
        chk("after_late_lat", 64'(lat), 64'(2));
        chk("after_late_rdata", rd, 64'h1122334455667788);
        chk("after_late_error", 64'(er), 64'(0));

        // Reset asserted while waiting in CSR_RESP
        write = 1'b0; addr = 16'h0010; req_valid = 1'b1; csr_req_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        csr_req_ready = 1'b0;
        chk("rstE_pre_resp", 64'(resp_valid), 64'(0));
        rst_n = 1'b0;
        #1;
        chk("rstE_req_ready", 64'(req_ready), 64'(1));
        chk("rstE_csr_req_valid", 64'(csr_req_valid), 64'(0));
        chk("rstE_resp_valid", 64'(resp_valid), 64'(0));
        chk("rstE_csr_resp_ready", 64'(csr_resp_ready), 64'(1));
        tick();
        rst_n = 1'b1;
        csr_resp_valid = 1'b1; csr_resp_data = 64'h555;
        tick();
        csr_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("rstE_no_resp", 64'(resp_valid), 64'(0));
            tick();
        end
        do_req(1'b0, 1'b0, 16'h1005, 64'h0, lat, rd, er, ia);
        chk("rstE_next_lat", 64'(lat), 64'(2));
        chk("rstE_next_rdata", rd, 64'h1122334455667788);

        // Error response held under backpressure
        write = 1'b0; addr = 16'h2000; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; addr = 16'h1005;
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", 64'(resp_valid), 64'(1));
            chk("hold_error", 64'(resp_error), 64'(1));
            chk("hold_rdata", resp_rdata, 64'h0);
            chk("hold_req_ready", 64'(req_ready), 64'(0));
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("hold_released", 64'(resp_valid), 64'(0));
        chk("hold_idle_ready", 64'(req_ready), 64'(1));

        // FPR window on the FPU-enabled instance
        do_req(1'b1, 1'b0, 16'h1023, 64'h0, lat, rd, er, ia);
        chk("fpr_lat", 64'(lat), 64'(2));
        chk("fpr_rdata", rd, 64'hF00DF00DCAFE0001);
        chk("fpr_error", 64'(er), 64'(0));
        chk("fpr_iaddr", 64'(ia), 64'(35));
        do_req(1'b1, 1'b0, 16'h2000, 64'h0, lat, rd, er, ia);
        chk("fpu_bad_lat", 64'(lat), 64'(1));
        chk("fpu_bad_error", 64'(er), 64'(1));
        chk("fpu_no_csr", 64'(act2), 64'(0));
        chk("fpu_csr_resp_ready", 64'(csr_resp_ready2), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
